uart_tx_port: RTL and testbench
===============================

UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clocks per serial bit (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cs  input  1  chip select, active low.
REQ-006 SHALL have port wr  input  1  write enable, active low; qualified by cs.
REQ-007 SHALL have port rd_strobe  input  1  read request pulse, active high; qualified by cs.
REQ-008 SHALL have port rd_busy  output  1  high while a read is in progress.
REQ-009 SHALL have port addr  input  3  register select.
REQ-010 SHALL have port in_data  input  8  write data.
REQ-011 SHALL have port out_data  output  8  registered read data.
REQ-012 SHALL have port tx_out  output  1  serial line, idle high.
REQ-013 SHALL have port irq  output  1  transmit-empty interrupt, active high.
REQ-014 SHALL have port tx_complete  output  1  one-cycle pulse after each stop bit ends.

Function
REQ-015 Register map SHALL be:
- addr 0 read: status {3'b0, overflow, irq_en, fifo_empty, fifo_full, tx_busy}.
- addr 0 write: bit3 = irq_en; bit7 = flush (self-clearing).
- addr 2 write: push in_data into the FIFO.
- All other addresses: reads return 8'h00, writes are ignored.
REQ-016 A write SHALL be accepted once, on the first cycle that (cs==0 && wr==0) holds after a cycle in which it did not hold; holding wr low SHALL NOT cause repeated pushes.
REQ-017 A read SHALL occur when cs==0 && rd_strobe==1.
- out_data SHALL be valid on the following cycle.
- rd_busy SHALL be high for exactly that one following cycle.
- out_data SHALL hold its value until the next read.
REQ-018 Reading status SHALL clear overflow on the cycle the read data is captured.
REQ-019 overflow SHALL be a sticky flag, set when a push arrives while the FIFO is full; the pushed byte SHALL be dropped and FIFO contents left unchanged.
REQ-020 If a push and a pop occur in the same cycle:
- FIFO not full: both SHALL take effect and the count SHALL be unchanged.
- FIFO full: both SHALL take effect and overflow SHALL NOT set.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-022 The serializer FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START when the FIFO is non-empty; the byte is popped into the shift register on that transition.
- START: tx_out=0 for CLKS_PER_BIT clocks, then -> DATA.
- DATA: 8 bits, LSB first, each for CLKS_PER_BIT clocks, then -> STOP.
- STOP: tx_out=1 for CLKS_PER_BIT clocks, then -> IDLE, with tx_complete pulsed on the final STOP cycle.
REQ-023 Latency: after a push to an empty FIFO with the FSM in IDLE, the pop SHALL occur on the next cycle and tx_out SHALL go low on the cycle after that.
REQ-024 Back-to-back frames SHALL have no idle gap: if the FIFO is non-empty at the end of STOP, the next START begins on the following cycle via IDLE for one cycle at most.
REQ-025 tx_busy SHALL be 1 whenever the FSM is not in IDLE.
REQ-026 flush SHALL empty the FIFO in the same cycle it is written; a frame already in flight SHALL complete unaltered.
REQ-027 If flush and a push occur in the same cycle, flush SHALL win and the byte SHALL be discarded.
REQ-028 irq SHALL equal irq_en && fifo_empty && !tx_busy, registered (one cycle of latency).
REQ-029 The bit-timing counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload at every state or bit boundary.

Reset
REQ-030 While reset==0, asynchronously:
- tx_out=1, tx_complete=0, irq=0, rd_busy=0, out_data=8'h00.
- FSM=IDLE, FIFO empty, irq_en=0, overflow=0, counters=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame and drive tx_out high immediately; the discarded byte SHALL NOT be retransmitted after release.
REQ-032 The block SHALL first accept bus writes on the first rising edge after reset deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Push 8'h3B -> tx_out low 2 cycles after the push, then bit pattern 1,1,0,1,1,1,0,0 (4 clocks each), stop high; tx_complete pulses once, 40 clocks after the start bit began.
REQ-034 Push 5 bytes while the FSM is busy with none drained -> 4 accepted, status bit4 (overflow)=1 and bit1 (fifo_full)=1; status read then bit4=0.
REQ-035 Push 8'hA5 and 8'h5A back-to-back -> two contiguous frames, each 40 clocks, at most one idle-high clock between them; irq_en=1 gives irq=1 after the second stop.
REQ-036 Hold cs=0, wr=0 for 10 cycles with addr=2 -> exactly one byte is pushed.
REQ-037 Push 3 bytes, then write flush mid-frame -> the current frame completes, the other 2 are never sent, fifo_empty=1.
REQ-038 Assert reset during DATA bit 3 -> tx_out=1 asynchronously, status=8'h04 after release, no further frames sent.

Source files
------------

// File: rtl/uart_tx_port.sv
// uart_tx_port: bus-attached 8N1 UART transmitter with a small TX FIFO.
// Registered read port; irq signals an idle transmitter with an empty FIFO.
module uart_tx_port #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd_strobe,
    output logic       rd_busy,
    input  logic [2:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       tx_out,
    output logic       irq,
    output logic       tx_complete
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_out_q;
    logic          tx_complete_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          wr_seen_q, wr_seen_d;
    logic          irq_en_q, irq_en_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          rd_busy_q, rd_busy_d;
    logic          irq_q, irq_d;

    logic       wr_act, wr_pulse, rd_act;
    logic       push_req, ctrl_wr, flush;
    logic       fifo_empty, fifo_full, tx_busy;
    logic       pop, push, ovf_set;
    logic [7:0] status, rdata;

    // Writes are edge-qualified so a held strobe pushes only once.
    assign wr_act   = !cs && !wr;
    assign wr_pulse = wr_act && !wr_seen_q;
    assign rd_act   = !cs && rd_strobe;

    assign push_req = wr_pulse && (addr == 3'd2);
    assign ctrl_wr  = wr_pulse && (addr == 3'd0);
    assign flush    = ctrl_wr && in_data[7];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign tx_busy    = (state_q != IDLE);

    assign pop     = !tx_busy && !fifo_empty && !flush;
    assign push    = push_req && !flush && (!fifo_full || pop);
    assign ovf_set = push_req && !flush && fifo_full && !pop;

    assign status = {3'b000, overflow_q, irq_en_q,
                     fifo_empty, fifo_full, tx_busy};
    assign rdata  = (addr == 3'd0) ? status : 8'h00;

    always_comb begin
        wr_seen_d  = wr_act;
        irq_en_d   = ctrl_wr ? in_data[3] : irq_en_q;
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (rd_act && (addr == 3'd0)) begin
            overflow_d = 1'b0;
        end
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            rptr_d  = wptr_q;
            count_d = '0;
        end else begin
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        out_data_d = rd_act ? rdata : out_data_q;
        rd_busy_d  = rd_act;
        irq_d      = irq_en_q && fifo_empty && !tx_busy;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            wr_seen_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            out_data_q <= 8'h00;
            rd_busy_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            wr_seen_q  <= wr_seen_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            out_data_q <= out_data_d;
            rd_busy_q  <= rd_busy_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            tx_out_q      <= 1'b1;
            tx_complete_q <= 1'b0;
        end else begin
            tx_complete_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q  <= START;
                        shift_q  <= mem_q[rptr_q];
                        cnt_q    <= '0;
                        tx_out_q <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= DATA;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        tx_out_q <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q  <= STOP;
                            tx_out_q <= 1'b1;
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            tx_out_q <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        tx_complete_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_out      = tx_out_q;
    assign tx_complete = tx_complete_q;
    assign irq         = irq_q;
    assign out_data    = out_data_q;
    assign rd_busy     = rd_busy_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frames are checked bit by bit against hand-derived 8N1 waveforms.
module tb_uart_tx_port;

    logic       clock;
    logic       reset;
    logic       cs;
    logic       wr;
    logic       rd_strobe;
    logic       rd_busy;
    logic [2:0] addr;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       tx_out;
    logic       irq;
    logic       tx_complete;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_port #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cs         (cs),
        .wr         (wr),
        .rd_strobe  (rd_strobe),
        .rd_busy    (rd_busy),
        .addr       (addr),
        .in_data    (in_data),
        .out_data   (out_data),
        .tx_out     (tx_out),
        .irq        (irq),
        .tx_complete(tx_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        tick();
        cs      = 1'b0;
        wr      = 1'b0;
        addr    = a;
        in_data = d;
        tick();
        cs = 1'b1;
        wr = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        cs        = 1'b0;
        rd_strobe = 1'b1;
        addr      = a;
        tick();
        cs        = 1'b1;
        rd_strobe = 1'b0;
        d         = out_data;
        check("rd_busy", 32'(rd_busy), 32'(1));
    endtask

    // Enter at frame sample k0 (k=0 is the first start-bit cycle).
    task automatic check_frame(input logic [7:0] b, input int k0);
        logic exp;
        int   pulses;
        pulses = 0;
        for (int k = k0; k < 40; k++) begin
            if (k < 4) exp = 1'b0;
            else if (k < 36) exp = b[3'((k - 4) / 4)];
            else exp = 1'b1;
            check($sformatf("tx %02h k%0d", b, k), 32'(tx_out), 32'(exp));
            pulses += int'(tx_complete);
            tick();
        end
        check($sformatf("early_done %02h", b), 32'(pulses), 32'(0));
        check($sformatf("tx_complete %02h", b), 32'(tx_complete), 32'(1));
    endtask

    task automatic next_frame(input logic [7:0] b);
        check($sformatf("gap %02h", b), 32'(tx_out), 32'(1));
        tick();
        check_frame(b, 0);
    endtask

    task automatic wait_complete(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            if (tx_complete) break;
            tick();
        end
        check({tag, " timeout"}, 32'(i < 200), 32'(1));
    endtask

    task automatic no_frame(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            lows += int'(!tx_out);
            tick();
        end
        check(tag, 32'(lows), 32'(0));
    endtask

    logic [7:0] rd;

    initial begin
        reset     = 1'b0;
        cs        = 1'b1;
        wr        = 1'b1;
        rd_strobe = 1'b0;
        addr      = 3'd0;
        in_data   = 8'h00;

        #12;
        check("rst tx_out", 32'(tx_out), 32'(1));
        check("rst tx_complete", 32'(tx_complete), 32'(0));
        check("rst irq", 32'(irq), 32'(0));
        check("rst rd_busy", 32'(rd_busy), 32'(0));
        check("rst out_data", 32'(out_data), 32'h00);
        #10;
        reset = 1'b1;
        tick();
        bus_read(3'd0, rd);
        check("rst status", 32'(rd), 32'h04);
        bus_read(3'd5, rd);
        check("unmapped read", 32'(rd), 32'h00);

        // Single frame, latency from push to start bit.
        bus_write(3'd2, 8'h3B);
        check("pop cycle tx", 32'(tx_out), 32'(1));
        tick();
        check_frame(8'h3B, 0);
        tick();
        check("complete one cycle", 32'(tx_complete), 32'(0));
        no_frame("idle after 3B", 20);

        // A held write strobe pushes once.
        tick();
        cs      = 1'b0;
        wr      = 1'b0;
        addr    = 3'd2;
        in_data = 8'h6C;
        repeat (10) tick();
        cs = 1'b1;
        wr = 1'b1;
        check_frame(8'h6C, 8);
        bus_read(3'd0, rd);
        check("hold status", 32'(rd), 32'h04);
        no_frame("hold single push", 50);

        // Overflow: one in flight, four queued, fifth dropped.
        bus_write(3'd2, 8'h11);
        tick();
        bus_write(3'd2, 8'h21);
        bus_write(3'd2, 8'h32);
        bus_write(3'd2, 8'h43);
        bus_write(3'd2, 8'h54);
        bus_write(3'd2, 8'h65);
        bus_read(3'd0, rd);
        check("ovf status", 32'(rd), 32'h13);
        bus_read(3'd0, rd);
        check("ovf cleared", 32'(rd), 32'h03);
        wait_complete("frame 11");
        next_frame(8'h21);
        next_frame(8'h32);
        next_frame(8'h43);
        next_frame(8'h54);
        no_frame("dropped byte", 50);
        bus_read(3'd0, rd);
        check("ovf drained", 32'(rd), 32'h04);

        // Back-to-back frames with irq enabled.
        bus_write(3'd0, 8'h08);
        tick();
        check("irq idle", 32'(irq), 32'(1));
        bus_write(3'd2, 8'hA5);
        bus_write(3'd2, 8'h5A);
        check_frame(8'hA5, 1);
        next_frame(8'h5A);
        tick();
        check("irq after stop", 32'(irq), 32'(1));
        bus_write(3'd0, 8'h00);
        tick();
        check("irq disabled", 32'(irq), 32'(0));

        // Flush mid-frame leaves the frame in flight intact.
        bus_write(3'd2, 8'h81);
        bus_write(3'd2, 8'h42);
        bus_write(3'd2, 8'h24);
        bus_write(3'd0, 8'h80);
        bus_read(3'd0, rd);
        check("flush status", 32'(rd), 32'h05);
        check_frame(8'h81, 6);
        no_frame("flushed bytes", 50);
        bus_read(3'd0, rd);
        check("flush idle status", 32'(rd), 32'h04);

        // Reset during DATA bit 3.
        bus_write(3'd2, 8'hC3);
        tick();
        repeat (17) tick();
        check("pre-reset tx", 32'(tx_out), 32'(0));
        #2;
        reset = 1'b0;
        #1;
        check("async tx_out", 32'(tx_out), 32'(1));
        check("async out_data", 32'(out_data), 32'h00);
        check("async rd_busy", 32'(rd_busy), 32'(0));
        check("async irq", 32'(irq), 32'(0));
        #3;
        reset = 1'b1;
        tick();
        bus_read(3'd0, rd);
        check("post-reset status", 32'(rd), 32'h04);
        no_frame("no retransmit", 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
